// File: rtl/guitar_pkg.sv
// Shared types and constants for the fret-note judging logic.
// The multiplier helper maps a consecutive-hit count to its 1..MAX_MULT scoring factor.
package guitar_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        TRACK  = 2'd1,
        WINDOW = 2'd2,
        JUDGED = 2'd3
    } judge_state_t;

    localparam int COMBO_STEP = 8;
    localparam int MAX_MULT   = 4;

    function automatic logic [2:0] mult_from_combo(input logic [7:0] combo);
        if (combo >= 8'(COMBO_STEP * (MAX_MULT - 1)))
            return 3'(MAX_MULT);
        return 3'(combo / 8'(COMBO_STEP)) + 3'd1;
    endfunction

endpackage

// File: rtl/rise_detect.sv
// Single-bit rising-edge detector: one-cycle pulse when the input goes high,
// with the history register cleared by an asynchronous reset.
module rise_detect (
    input  logic clk_i,
    input  logic rst_i,
    input  logic d_i,
    output logic rise_o
);

    logic prev_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)
            prev_q <= 1'b0;
        else
            prev_q <= d_i;
    end

    assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/note_judge_red.sv
// Red-lane note judge: tracks one falling note through the strum window, scores hits,
// counts misses and ghost strums, and drives the combo, multiplier and hit flash.
module note_judge_red
    import guitar_pkg::*;
#(
    parameter logic [9:0]  WIN_LO       = 10'd400,
    parameter logic [9:0]  WIN_HI       = 10'd440,
    parameter logic [15:0] HIT_POINTS   = 16'd10,
    parameter logic [3:0]  FLASH_FRAMES = 4'd15
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        frame_clk,
    input  logic [9:0]  note_y_pos,
    input  logic        note_active,
    input  logic        key_red,
    output logic        hit_pulse,
    output logic        miss_pulse,
    output logic [15:0] score,
    output logic [7:0]  combo,
    output logic [2:0]  multiplier,
    output logic        hit_flash
);

    judge_state_t state_q, state_d;
    logic         strum, tick;
    logic         hit_d, miss_d;
    logic         hit_q, miss_q;
    logic [15:0]  score_q, score_d;
    logic [7:0]   combo_q, combo_d;
    logic [3:0]   flash_q, flash_d;
    logic [2:0]   mult;
    logic [18:0]  score_sum;
    logic         above_win, in_win, past_win;

    rise_detect u_key_rise (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .d_i    (key_red),
        .rise_o (strum)
    );

    rise_detect u_frame_rise (
        .clk_i  (Clk),
        .rst_i  (Reset),
        .d_i    (frame_clk),
        .rise_o (tick)
    );

    assign above_win = note_y_pos < WIN_LO;
    assign past_win  = note_y_pos > WIN_HI;
    assign in_win    = !above_win && !past_win;

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:   if (note_active && above_win) state_d = TRACK;
            TRACK: begin
                if (!note_active)
                    state_d = IDLE;
                else if (in_win)
                    state_d = WINDOW;
            end
            WINDOW: if (strum || past_win || !note_active) state_d = JUDGED;
            JUDGED: if (!note_active || above_win) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // A strum inside the window always wins over the note leaving it in the same cycle.
    always_comb begin
        hit_d  = 1'b0;
        miss_d = 1'b0;
        if (state_q == WINDOW) begin
            if (strum)
                hit_d = 1'b1;
            else if (past_win || !note_active)
                miss_d = 1'b1;
        end else if (strum) begin
            miss_d = 1'b1;
        end
    end

    assign mult      = mult_from_combo(combo_q);
    assign score_sum = 19'(score_q) + 19'(HIT_POINTS) * 19'(mult);

    always_comb begin
        score_d = score_q;
        combo_d = combo_q;
        flash_d = flash_q;
        if (hit_d) begin
            score_d = (score_sum > 19'h0FFFF) ? 16'hFFFF : score_sum[15:0];
            combo_d = (combo_q == 8'hFF) ? 8'hFF : combo_q + 8'd1;
            flash_d = FLASH_FRAMES;
        end else begin
            if (miss_d)
                combo_d = 8'd0;
            if (tick && flash_q != 4'd0)
                flash_d = flash_q - 4'd1;
        end
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            hit_q   <= 1'b0;
            miss_q  <= 1'b0;
            score_q <= 16'd0;
            combo_q <= 8'd0;
            flash_q <= 4'd0;
        end else begin
            hit_q   <= hit_d;
            miss_q  <= miss_d;
            score_q <= score_d;
            combo_q <= combo_d;
            flash_q <= flash_d;
        end
    end

    assign hit_pulse  = hit_q;
    assign miss_pulse = miss_q;
    assign score      = score_q;
    assign combo      = combo_q;
    assign multiplier = mult;
    assign hit_flash  = flash_q != 4'd0;

endmodule

// File: doc/note_judge_red.md
NOTE_JUDGE_RED -- requirements
Module: note_judge_red

Interface
REQ-001 SHALL have parameter WIN_LO, default 10'd400, the lowest note top-edge Y inside the strum window.
REQ-002 SHALL have parameter WIN_HI, default 10'd440, the highest note top-edge Y inside the strum window.
REQ-003 SHALL have parameter HIT_POINTS, default 16'd10, the base points per hit.
REQ-004 SHALL have parameter FLASH_FRAMES, default 4'd15, the hit-flash duration in frames.
REQ-005 SHALL have port Clk  input  1  50 MHz system clock; one clock domain.
REQ-006 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-007 SHALL have port frame_clk  input  1  frame strobe (~60 Hz).
REQ-008 SHALL have port note_y_pos  input  10  top-edge Y of the red note.
REQ-009 SHALL have port note_active  input  1  high while the red note is falling and visible.
REQ-010 SHALL have port key_red  input  1  red fret key level, synchronous to Clk.
REQ-011 SHALL have port hit_pulse  output  1  one-Clk pulse per successful hit.
REQ-012 SHALL have port miss_pulse  output  1  one-Clk pulse per missed note or ghost strum.
REQ-013 SHALL have port score  output  16  running score.
REQ-014 SHALL have port combo  output  8  count of consecutive hits.
REQ-015 SHALL have port multiplier  output  3  current multiplier, 1..4.
REQ-016 SHALL have port hit_flash  output  1  high for FLASH_FRAMES frames after a hit.

Function
REQ-017 SHALL detect a key strum as key_red high with its previous-cycle register low; holding the key SHALL NOT re-strum.
REQ-018 SHALL detect a frame tick as the rising edge of frame_clk, registered once in Clk.
REQ-019 SHALL implement FSM states IDLE, TRACK, WINDOW and JUDGED.
REQ-020 IDLE SHALL go to TRACK when note_active=1 and note_y_pos<WIN_LO.
REQ-021 TRACK SHALL go to WINDOW when WIN_LO<=note_y_pos<=WIN_HI, and to IDLE when note_active=0.
REQ-022 WINDOW with a strum SHALL register a hit: pulse hit_pulse and go to JUDGED.
REQ-023 A WINDOW strum SHALL count as a hit regardless of note_y_pos in the same cycle, so a simultaneous strum and window exit is a hit.
REQ-024 WINDOW with no strum and either note_y_pos>WIN_HI or note_active=0 SHALL register a miss: pulse miss_pulse and go to JUDGED.
REQ-025 JUDGED SHALL go to IDLE when note_active=0 or note_y_pos<WIN_LO (note wrap); no second judgement per note.
REQ-026 A strum in IDLE, TRACK or JUDGED SHALL be a ghost strum: pulse miss_pulse and clear combo, with score unchanged.
REQ-027 The multiplier SHALL be 1 for combo 0-7, 2 for 8-15, 3 for 16-23 and 4 for 24 or more, computed combinationally from the registered combo.
REQ-028 On a hit, score SHALL increase by HIT_POINTS*multiplier, using the multiplier before the combo increments, and SHALL saturate at 16'hFFFF.
REQ-029 On a hit, combo SHALL increment and saturate at 8'd255; on a miss or ghost strum, combo SHALL clear to 0.
REQ-030 hit_pulse, miss_pulse, score and combo SHALL update in the Clk cycle after the deciding edge; latency is 1 cycle.
REQ-031 hit_pulse and miss_pulse SHALL never be high in the same cycle.
REQ-032 On a hit, a 4-bit flash counter SHALL load FLASH_FRAMES; it SHALL decrement on each frame tick while nonzero.
REQ-033 hit_flash SHALL be high while the flash counter is nonzero; a new hit SHALL reload the counter.

Reset
REQ-034 Reset=1 SHALL asynchronously force: state IDLE, score 0, combo 0, flash counter 0, key and frame_clk history registers 0, hit_pulse 0, miss_pulse 0; multiplier then reads 1.
REQ-035 Reset asserted mid-WINDOW SHALL abort the judgement with no pulse; after release the FSM SHALL re-enter from IDLE.

Structure
REQ-036 Package guitar_pkg SHALL hold judge_state_t (the 4-state enum) and the constants COMBO_STEP=8 and MAX_MULT=4.
REQ-037 Sub-module rise_detect SHALL implement the 1-bit rising-edge detect with asynchronous reset, instantiated for key_red and frame_clk.
REQ-038 Implementation SHALL be 120-400 lines of RTL.

Verification
REQ-039 Note at y=405, note_active=1, strum -> hit_pulse 1 cycle later, score 10, combo 1, hit_flash high for 15 frame ticks.
REQ-040 Note passes y=443 with no strum -> one miss_pulse, combo 0, score unchanged.
REQ-041 Ten consecutive window hits -> scores 10,20,...,80,100,120 (hits 9 and 10 at multiplier 2), combo 10, multiplier 2.
REQ-042 Strum with note at y=100 while combo is 5 -> miss_pulse, combo 0, score unchanged, FSM stays in TRACK, and a later window strum still hits.
REQ-043 Score preset near 16'hFFF8 with multiplier 4, hit -> score 16'hFFFF; key held 100 cycles -> exactly one strum.
REQ-044 Reset pulsed while in WINDOW -> no pulses, all outputs at reset values, next note judged normally.
